jump_charge_ctrl: RTL

JUMP_CHARGE_CTRL -- requirements
Module: jump_charge_ctrl

---
 rtl/jump_charge_ctrl_if.sv | 12 +
 rtl/jump_charge_ctrl.sv | 137 +++++++++++++
 2 files changed

// File: rtl/jump_charge_ctrl_if.sv
// rtl/jump_charge_ctrl_if.sv - button/tick/busy inputs and jump charge outputs of jump_charge_ctrl
interface jump_charge_ctrl_if;
  logic       btn;
  logic       tick;
  logic       busy;
  logic [7:0] jump_dist;
  logic       charging;
  logic       fired;

  modport master (output btn, tick, busy, input jump_dist, charging, fired);
  modport slave  (input btn, tick, busy, output jump_dist, charging, fired);
endinterface

// File: rtl/jump_charge_ctrl.sv
// rtl/jump_charge_ctrl.sv - jump charge controller: button sync/debounce, tick-driven charge, fire and lockout
// Optional macro JUMP_AUTOFIRE_EN: leave CHARGE automatically once the charge saturates at MAX_DIST.
module jump_charge_ctrl #(
  parameter int DEB_CYCLES  = 4,
  parameter int CHARGE_STEP = 1,
  parameter int MAX_DIST    = 63,
  parameter int LOCK_TICKS  = 20
) (
  input  logic              clk,
  input  logic              restart,
  jump_charge_ctrl_if.slave jc
);
  localparam int CW = $clog2(DEB_CYCLES + 1);
  localparam int LW = (LOCK_TICKS < 2) ? 1 : $clog2(LOCK_TICKS + 1);
  localparam logic [8:0]    STEP9  = 9'(CHARGE_STEP);
  localparam logic [8:0]    MAX9   = 9'(MAX_DIST);
  localparam logic [CW-1:0] DEB_N  = CW'(DEB_CYCLES);
  localparam logic [LW-1:0] LOCK_N = LW'(LOCK_TICKS);

  typedef enum logic [2:0] {IDLE, CHARGE, HOLD, ZERO, LOCK} state_t;

  state_t        state;
  logic [1:0]    sync, fill;
  logic          run_lvl, deb, deb_prev, deb_known;
  logic [CW-1:0] run_cnt, run_next;
  logic [7:0]    charge, c_inc;
  logic [8:0]    c_sum;
  logic [LW-1:0] lock_cnt;
  logic          samp, valid, deb_rise, deb_fall, auto_hit, empty_release;

  assign samp     = sync[1];
  assign valid    = fill[1];
  assign deb_rise = deb & ~deb_prev;
  assign deb_fall = ~deb & deb_prev;

  // run_next: length of the run of identical valid samples, saturating at DEB_CYCLES
  always_comb begin
    run_next = CW'(1);
    if (samp == run_lvl && run_cnt != '0)
      run_next = (run_cnt == DEB_N) ? run_cnt : run_cnt + CW'(1);
  end

  assign c_sum         = {1'b0, charge} + STEP9;
  assign c_inc         = (c_sum > MAX9) ? MAX9[7:0] : c_sum[7:0];
  assign empty_release = deb_fall && ((jc.tick ? c_inc : charge) == 8'd0);

`ifdef JUMP_AUTOFIRE_EN
  assign auto_hit = jc.tick && (c_inc == MAX9[7:0]);
`else
  assign auto_hit = 1'b0;
`endif

  // The first debounced level after restart is adopted silently, so a button
  // held through restart produces no rising edge until it is released first.
  always_ff @(posedge clk) begin
    if (restart) begin
      sync      <= '0;
      fill      <= '0;
      run_lvl   <= 1'b0;
      run_cnt   <= '0;
      deb       <= 1'b0;
      deb_prev  <= 1'b0;
      deb_known <= 1'b0;
    end else begin
      sync     <= {sync[0], jc.btn};
      fill     <= {fill[0], 1'b1};
      deb_prev <= deb;
      if (valid) begin
        run_lvl <= samp;
        run_cnt <= run_next;
        if (run_next == DEB_N) begin
          deb <= samp;
          if (!deb_known) begin
            deb_prev  <= samp;
            deb_known <= 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (restart) begin
      state        <= IDLE;
      charge       <= '0;
      lock_cnt     <= '0;
      jc.jump_dist <= '0;
      jc.charging  <= 1'b0;
      jc.fired     <= 1'b0;
    end else begin
      jc.fired <= 1'b0;
      unique case (state)
        IDLE: begin
          if (deb_rise && !jc.busy) begin
            state       <= CHARGE;
            charge      <= '0;
            jc.charging <= 1'b1;
          end
        end
        CHARGE: begin
          if (jc.tick) begin
            charge       <= c_inc;
            jc.jump_dist <= c_inc;
          end
          if (empty_release) begin
            state        <= IDLE;
            jc.charging  <= 1'b0;
            jc.jump_dist <= '0;
          end else if (deb_fall || auto_hit) begin
            state       <= HOLD;
            jc.charging <= 1'b0;
          end
        end
        HOLD: begin
          if (jc.tick) begin
            state        <= ZERO;
            jc.jump_dist <= '0;
          end
        end
        ZERO: begin
          if (jc.tick) begin
            state    <= LOCK;
            jc.fired <= 1'b1;
            lock_cnt <= LOCK_N;
          end
        end
        LOCK: begin
          if (lock_cnt == '0 && !jc.busy && !deb)
            state <= IDLE;
          else if (jc.tick && lock_cnt != '0)
            lock_cnt <= lock_cnt - LW'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
